// File: rtl/branch_unit_bp_pkg.sv
// ----------------------------------------------------------------------------
// branch_pkg
//   Shared types and helpers for the branch resolution unit and its branch
//   history table (BHT): the branch funct3 encodings, the 2-bit saturating
//   counter type, its named states and the counter update function.
// ----------------------------------------------------------------------------
package branch_pkg;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } br_funct3_e;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t CTR_SNT = 2'b00;  // strongly not-taken
    localparam bht_ctr_t CTR_WNT = 2'b01;  // weakly not-taken (reset value)
    localparam bht_ctr_t CTR_ST  = 2'b11;  // strongly taken

    // Two-bit saturating counter step: count up on taken, down on not-taken,
    // clamping at both ends.
    function automatic bht_ctr_t sat_update(bht_ctr_t ctr, logic taken);
        bht_ctr_t nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != CTR_ST) nxt = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_unit_bp_if.sv
// ----------------------------------------------------------------------------
// branch_unit_bp_if
//   Fetch-prediction and execute-resolution signals of the branch unit.
//   master : pipeline side (drives fetch PC and the branch in execute)
//   slave  : branch unit side (returns prediction and resolution)
// ----------------------------------------------------------------------------
interface branch_unit_bp_if #(
    parameter int XLEN = 32
);
    // fetch side
    logic [XLEN-1:0] fetch_pc;
    logic            fetch_pred_taken;
    // execute side, request
    logic            br_valid;
    logic [2:0]      br_funct3;
    logic [XLEN-1:0] br_pc;
    logic [XLEN-1:0] br_imm;
    logic [XLEN-1:0] br_rs1;
    logic [XLEN-1:0] br_rs2;
    logic            br_pred_taken;
    // execute side, resolution
    logic            res_taken;
    logic [XLEN-1:0] res_target;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;
    logic            br_illegal;

    modport master (
        output fetch_pc, br_valid, br_funct3, br_pc, br_imm, br_rs1, br_rs2,
               br_pred_taken,
        input  fetch_pred_taken, res_taken, res_target, mispredict,
               redirect_pc, br_illegal
    );

    modport slave (
        input  fetch_pc, br_valid, br_funct3, br_pc, br_imm, br_rs1, br_rs2,
               br_pred_taken,
        output fetch_pred_taken, res_taken, res_target, mispredict,
               redirect_pc, br_illegal
    );
endinterface

// File: rtl/branch_unit_bp_bht.sv
// ----------------------------------------------------------------------------
// bht_table
//   Array of 2-bit saturating counters with one asynchronous read port and
//   one saturating-update write port. Synchronous active-high reset sets
//   every counter to weakly not-taken.
//   Optional macro BP_BYPASS_EN: a read that hits the index being written
//   this cycle returns the post-update counter value.
//
//   clk, rst   : clock, synchronous active-high reset
//   rd_idx     : read index            rd_ctr   : counter at rd_idx
//   wr_en      : apply an update       wr_idx   : counter to update
//   wr_taken   : update direction
// ----------------------------------------------------------------------------
module bht_table
    import branch_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output bht_ctr_t         rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    bht_ctr_t ctr [DEPTH];

    // NOTE: the table is built from flops, not a RAM macro, so every entry can
    // be reset; the predictor must start from a known weakly-not-taken state.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ctr[i] <= CTR_WNT;
        end else if (wr_en) begin
            ctr[wr_idx] <= sat_update(ctr[wr_idx], wr_taken);
        end
    end

`ifdef BP_BYPASS_EN
    always_comb begin
        // NOTE: default first so no path leaves rd_ctr unassigned (no latch).
        rd_ctr = ctr[rd_idx];
        if (wr_en && (wr_idx == rd_idx)) rd_ctr = sat_update(ctr[wr_idx], wr_taken);
    end
`else
    assign rd_ctr = ctr[rd_idx];
`endif

endmodule

// File: rtl/branch_unit_bp.sv
// ----------------------------------------------------------------------------
// branch_unit_bp
//   Branch resolution unit with a 2-bit BHT predictor for the RV32 core.
//   Resolution (compare, target, redirect, mispredict) is combinational.
//   Resolved legal branches are registered in an update stage and written
//   to the BHT on the following edge.
//   Optional macro BP_BYPASS_EN (in bht_table): forward the pending update
//   to the fetch prediction.
//
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : branch_unit_bp_if.slave (fetch prediction + execute resolution)
// ----------------------------------------------------------------------------
module branch_unit_bp
    import branch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    branch_unit_bp_if.slave    bus
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    // ---------------- resolution ----------------
    logic cond_true;
    logic funct_bad;

    always_comb begin
        cond_true = 1'b0;
        funct_bad = 1'b0;
        case (br_funct3_e'(bus.br_funct3))
            BR_BEQ:  cond_true = (bus.br_rs1 == bus.br_rs2);
            BR_BNE:  cond_true = (bus.br_rs1 != bus.br_rs2);
            BR_BLT:  cond_true = ($signed(bus.br_rs1) <  $signed(bus.br_rs2));
            BR_BGE:  cond_true = ($signed(bus.br_rs1) >= $signed(bus.br_rs2));
            BR_BLTU: cond_true = (bus.br_rs1 <  bus.br_rs2);
            BR_BGEU: cond_true = (bus.br_rs1 >= bus.br_rs2);
            default: funct_bad = 1'b1;   // 010 / 011 are not branches
        endcase
    end

    logic res_taken;
    assign res_taken      = bus.br_valid & cond_true;
    assign bus.res_taken  = res_taken;
    assign bus.br_illegal = bus.br_valid & funct_bad;
    assign bus.mispredict = bus.br_valid & (res_taken != bus.br_pred_taken);

    // Plain wrap-around add; the immediate is already sign-extended.
    assign bus.res_target  = bus.br_pc + (bus.br_imm << 1);
    assign bus.redirect_pc = res_taken ? bus.res_target : bus.br_pc + XLEN'(4);

    // ---------------- update stage ----------------
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;

    always_ff @(posedge clk) begin
        if (rst) upd_valid <= 1'b0;
        else     upd_valid <= bus.br_valid & ~funct_bad;
        // Payload is qualified by upd_valid and needs no reset.
        upd_idx   <= bus.br_pc[IDX_W+1:2];
        upd_taken <= res_taken;
    end

    // ---------------- prediction table ----------------
    bht_ctr_t fetch_ctr;

    bht_table #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (bus.fetch_pc[IDX_W+1:2]),
        .rd_ctr   (fetch_ctr),
        .wr_en    (upd_valid),
        .wr_idx   (upd_idx),
        .wr_taken (upd_taken)
    );

    assign bus.fetch_pred_taken = fetch_ctr[1];

endmodule

// File: tb/tb_branch_unit_bp.sv
// ----------------------------------------------------------------------------
// tb_branch_unit_bp
//   Directed scenarios with literal expectations, then randomized traffic.
//   A behavioural model (integer counters plus a queue of resolved branches
//   that become visible a fixed number of cycles later) is checked against
//   the DUT on every falling edge.
// ----------------------------------------------------------------------------
module tb_branch_unit_bp;

    localparam int XLEN  = 32;
    localparam int DEPTH = 64;
`ifdef BP_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_unit_bp_if #(.XLEN(XLEN)) bus ();

    branch_unit_bp #(.XLEN(XLEN), .BHT_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int idx;
        bit taken;
        int cyc;
    } resolve_t;

    int       m_ctr [DEPTH];
    resolve_t pend[$];
    int       cyc = 0;
    bit       model_ok = 0;

    function automatic bit m_legal(input logic [2:0] f);
        return !(f == 3'd2 || f == 3'd3);
    endfunction

    function automatic bit m_cond(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int     sa = a;
        int     sb = b;
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        case (f)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return sa < sb;
            3'd5:    return sa >= sb;
            3'd6:    return ua < ub;
            3'd7:    return ua >= ub;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] pc, input logic [31:0] imm);
        longint s;
        s = longint'({32'd0, pc}) + 2 * longint'($signed(imm));
        return s[31:0];
    endfunction

    function automatic int m_idx(input logic [31:0] pc);
        return (int'(pc) >> 2) & (DEPTH - 1);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_ctr[i] = 1;
            pend.delete();
            model_ok = 1;
        end else if (model_ok && bus.br_valid && m_legal(bus.br_funct3)) begin
            pend.push_back('{m_idx(bus.br_pc),
                             m_cond(bus.br_funct3, bus.br_rs1, bus.br_rs2), cyc});
        end
        cyc++;
        while (pend.size() > 0 && pend[0].cyc + LAT <= cyc) begin
            if (pend[0].taken) m_ctr[pend[0].idx] = (m_ctr[pend[0].idx] == 3) ? 3 : m_ctr[pend[0].idx] + 1;
            else               m_ctr[pend[0].idx] = (m_ctr[pend[0].idx] == 0) ? 0 : m_ctr[pend[0].idx] - 1;
            void'(pend.pop_front());
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (model_ok) begin
            bit          e_taken;
            logic [31:0] e_tgt;
            e_taken = bus.br_valid && m_cond(bus.br_funct3, bus.br_rs1, bus.br_rs2);
            e_tgt   = m_target(bus.br_pc, bus.br_imm);
            check("cmp_pred", {31'd0, bus.fetch_pred_taken}, {31'd0, m_ctr[m_idx(bus.fetch_pc)] >= 2});
            check("cmp_taken", {31'd0, bus.res_taken}, {31'd0, e_taken});
            check("cmp_illegal", {31'd0, bus.br_illegal},
                  {31'd0, bus.br_valid && !m_legal(bus.br_funct3)});
            check("cmp_mispredict", {31'd0, bus.mispredict},
                  {31'd0, bus.br_valid && (e_taken != bus.br_pred_taken)});
            if (bus.br_valid) begin
                check("cmp_target", bus.res_target, e_tgt);
                check("cmp_redirect", bus.redirect_pc, e_taken ? e_tgt : bus.br_pc + 32'd4);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic br(input logic [2:0] f, input logic [31:0] pc, input logic [31:0] imm,
                      input logic [31:0] a, input logic [31:0] b, input logic p);
        bus.br_valid      = 1'b1;
        bus.br_funct3     = f;
        bus.br_pc         = pc;
        bus.br_imm        = imm;
        bus.br_rs1        = a;
        bus.br_rs2        = b;
        bus.br_pred_taken = p;
    endtask

    task automatic idle();
        bus.br_valid = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        bus.fetch_pc = 32'h100;
        br(3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1 check("rst_pred_100", {31'd0, bus.fetch_pred_taken}, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            bus.fetch_pc = 32'(i) << 2;
            #1 check("rst_pred_idx", {31'd0, bus.fetch_pred_taken}, 32'd0);
        end

        // BEQ equal operands, predicted not-taken
        tick(); br(3'd0, 32'h200, 32'h10, 32'd5, 32'd5, 1'b0);
        #1 check("beq_taken", {31'd0, bus.res_taken}, 32'd1);
        check("beq_mispredict", {31'd0, bus.mispredict}, 32'd1);
        check("beq_redirect", bus.redirect_pc, 32'h220);

        // Target wrap and negative offsets
        tick(); br(3'd0, 32'h10, 32'hFFFF_FFF8, 32'd1, 32'd2, 1'b0);
        #1 check("tgt_neg", bus.res_target, 32'h0);
        check("tgt_neg_redirect", bus.redirect_pc, 32'h14);
        tick(); br(3'd0, 32'hFFFF_FFFC, 32'd4, 32'd1, 32'd2, 1'b0);
        #1 check("tgt_wrap", bus.res_target, 32'h4);
        tick(); br(3'd1, 32'h300, 32'h40, 32'd7, 32'd7, 1'b1);
        #1 check("bne_nt_redirect", bus.redirect_pc, 32'h304);
        check("bne_nt_mispredict", {31'd0, bus.mispredict}, 32'd1);

        // Signed vs unsigned
        tick(); br(3'd4, 32'h400, 32'h8, 32'hFFFF_FFFF, 32'd1, 1'b0);
        #1 check("blt", {31'd0, bus.res_taken}, 32'd1);
        check("blt_redirect", bus.redirect_pc, 32'h410);
        tick(); br(3'd6, 32'h400, 32'h8, 32'hFFFF_FFFF, 32'd1, 1'b0);
        #1 check("bltu", {31'd0, bus.res_taken}, 32'd0);
        tick(); br(3'd5, 32'h400, 32'h8, 32'hFFFF_FFFF, 32'd1, 1'b0);
        #1 check("bge", {31'd0, bus.res_taken}, 32'd0);
        tick(); br(3'd7, 32'h400, 32'h8, 32'hFFFF_FFFF, 32'd1, 1'b0);
        #1 check("bgeu", {31'd0, bus.res_taken}, 32'd1);

        // Training: three taken, then two not-taken at 0x40
        do_reset();
        bus.fetch_pc = 32'h40;
        br(3'd0, 32'h40, 32'h20, 32'd3, 32'd3, 1'b0);
        #1 check("train_n0", {31'd0, bus.fetch_pred_taken}, 32'd0);
        tick(); br(3'd0, 32'h40, 32'h20, 32'd3, 32'd3, 1'b0);
        #1 check("train_n1", {31'd0, bus.fetch_pred_taken}, (LAT == 1) ? 32'd1 : 32'd0);
        tick(); br(3'd0, 32'h40, 32'h20, 32'd3, 32'd3, 1'b0);
        #1 check("train_n2", {31'd0, bus.fetch_pred_taken}, 32'd1);
        tick(); br(3'd0, 32'h40, 32'h20, 32'd3, 32'd4, 1'b1);
        #1 check("train_n3", {31'd0, bus.fetch_pred_taken}, 32'd1);
        tick(); br(3'd0, 32'h40, 32'h20, 32'd3, 32'd4, 1'b1);
        #1 check("train_n4", {31'd0, bus.fetch_pred_taken}, 32'd1);
        tick(); idle();
        #1 check("train_n5", {31'd0, bus.fetch_pred_taken}, (LAT == 2) ? 32'd1 : 32'd0);
        tick();
        #1 check("train_n6", {31'd0, bus.fetch_pred_taken}, 32'd0);

        // Aliasing: 0x40 and 0x140 share an index
        do_reset();
        br(3'd0, 32'h40, 32'h20, 32'd3, 32'd3, 1'b0);
        tick();
        tick(); idle();
        tick();
        bus.fetch_pc = 32'h140;
        #1 check("alias_140", {31'd0, bus.fetch_pred_taken}, 32'd1);

        // Illegal funct3 leaves the counter alone
        do_reset();
        bus.fetch_pc = 32'h80;
        br(3'd0, 32'h80, 32'h20, 32'd1, 32'd1, 1'b0);   // counter 01 -> 10
        tick(); br(3'd2, 32'h80, 32'h20, 32'd1, 32'd1, 1'b1);
        #1 check("ill_flag", {31'd0, bus.br_illegal}, 32'd1);
        check("ill_taken", {31'd0, bus.res_taken}, 32'd0);
        check("ill_mispredict", {31'd0, bus.mispredict}, 32'd1);
        tick(); br(3'd3, 32'h80, 32'h20, 32'd1, 32'd2, 1'b0);
        tick(); idle();
        tick();
        #1 check("ill_ctr_kept", {31'd0, bus.fetch_pred_taken}, 32'd1);

        // Reset right after a taken resolve drops the pending update
        do_reset();
        bus.fetch_pc = 32'h40;
        br(3'd0, 32'h40, 32'h20, 32'd9, 32'd9, 1'b0);
        tick(); idle(); rst = 1'b1;
        tick(); rst = 1'b0;
        #1 check("rst_drop_a", {31'd0, bus.fetch_pred_taken}, 32'd0);
        tick();
        #1 check("rst_drop_b", {31'd0, bus.fetch_pred_taken}, 32'd0);

        // Randomized traffic over a small index set to force reuse
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            tick();
            rst = ($urandom_range(0, 299) == 0);
            a = $urandom();
            br(3'($urandom_range(0, 7)),
               ($urandom() & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3)),
               $urandom(), a, ($urandom_range(0, 3) == 0) ? a : $urandom(),
               1'($urandom_range(0, 1)));
            bus.br_valid = ($urandom_range(0, 3) != 0);
            bus.fetch_pc = ($urandom() & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
        end
        tick(); rst = 1'b0; idle();
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_unit_bp.md
Name: branch_unit_bp

Overview:
- Parametrised branch resolution unit for the RV32 core.
- Compares operands for all six conditional branch types and forms the target as `pc + (imm << 1)` using signed, wrap-around addition.
- Reads a 2-bit saturating-counter branch history table (BHT) at fetch to give a prediction.
- At execute, produces the resolved outcome, mispredict flag and redirect PC, and trains the BHT through a registered update stage.

Parameters:
- XLEN, 32, datapath/PC width.
- BHT_DEPTH, 64, number of counters; power of two, ≥2.
- IDX_W, $clog2(BHT_DEPTH), BHT index width (derived, not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- fetch_pc  in  XLEN  PC being fetched
- fetch_pred_taken  out  1  prediction = MSB of counter at fetch_pc[IDX_W+1:2]
- br_valid  in  1  conditional branch in execute this cycle
- br_funct3  in  3  branch type (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111)
- br_pc  in  XLEN  PC of the branch
- br_imm  in  XLEN  sign-extended immediate, unshifted
- br_rs1, br_rs2  in  XLEN  operands
- br_pred_taken  in  1  prediction carried with the branch from fetch
- res_taken  out  1  resolved outcome
- res_target  out  XLEN  br_pc + (br_imm << 1), mod 2^XLEN
- mispredict  out  1  br_valid & (res_taken != br_pred_taken)
- redirect_pc  out  XLEN  res_taken ? res_target : br_pc + 4
- br_illegal  out  1  br_valid with funct3 010/011

Behaviour:
- Clock and reset: single clock `clk`; `rst` is synchronous and active-high.
- Resolution path is combinational, zero latency; only BHT and update stage are sequential.
- res_target: always computed as plain XLEN two's-complement addition. No sign-based subtract path. Overflow wraps.
- Comparisons:
  - BLT/BGE: signed.
  - BLTU/BGEU: unsigned.
- Illegal funct3:
  - res_taken = 0, br_illegal = 1.
  - No BHT update.
  - mispredict still computed from res_taken = 0.
- When br_valid = 0: res_taken, mispredict, br_illegal are 0; res_target and redirect_pc are don't-care but deterministic.
- Update stage: on a clock edge with br_valid & ~br_illegal, capture upd_valid = 1, upd_idx = br_pc[IDX_W+1:2], upd_taken = res_taken. Otherwise upd_valid is cleared.
- Table write: on the next edge, if upd_valid, ctr[upd_idx] saturates up (taken) or down (not taken).
  - Transitions: 00 → 01 → 10 → 11 on taken; reverse on not-taken.
  - Clamp at 00 and 11.
- Training latency: a resolve in cycle N is visible at fetch_pred_taken from cycle N+2 (no bypass).
- Back-to-back branches to the same index: each update applies in order, one per cycle. No merging or loss.
- Reset:
  - All counters go to 01 (weakly not-taken).
  - upd_valid goes to 0.
  - fetch_pred_taken = 0 from the cycle after reset.
  - Reset mid-operation discards any pending update.
- PC bits [1:0] and bits above IDX_W+1 are ignored for indexing (aliasing accepted).

Optional Feature:
- Macro: BP_BYPASS_EN.
- Defined: if upd_valid and fetch index == upd_idx, fetch_pred_taken is the MSB of the post-update counter value. This reduces training latency to N+1.
- Undefined: no forwarding; prediction reads the stored counter only. Latency N+2 as above.

Decomposition:
- Shared package branch_pkg:
  - br_funct3_e enum with the six encodings.
  - bht_ctr_t (logic [1:0]).
  - Constants CTR_WNT = 2'b01, CTR_SNT = 2'b00, CTR_ST = 2'b11.
  - Function sat_update(bht_ctr_t, logic taken).
- Sub-module bht_table: counter array with reset, one async read port, one write port, and the BP_BYPASS_EN forwarding.
- branch_unit_bp holds compare, target, redirect and update-stage logic.

Test Plan:
- Reset then fetch_pc = 0x100:
  - fetch_pred_taken = 0 at every index.
  - BEQ br_valid with rs1 = rs2 = 5, br_pred_taken = 0 → res_taken = 1, mispredict = 1.
- Target wrap and negative offsets:
  - br_pc = 0x0000_0010, imm = 0xFFFF_FFF8 → res_target = 0x0000_0000.
  - br_pc = 0xFFFF_FFFC, imm = 4 → res_target = 0x0000_0004.
  - Not-taken BNE (rs1 = rs2) → redirect_pc = br_pc + 4.
- Signed vs unsigned, rs1 = 0xFFFF_FFFF, rs2 = 1 → BLT taken, BLTU not taken, BGE not taken, BGEU taken.
- Training, three taken resolves at br_pc = 0x40 in consecutive cycles N..N+2:
  - fetch_pc = 0x40 prediction 0 through N+1, 1 from N+2 (N+1 with BP_BYPASS_EN).
  - Counter saturates at 11.
  - Two not-taken resolves → counter 01, prediction 0.
- Aliasing: BHT_DEPTH = 64, train br_pc = 0x40 taken twice → fetch_pc = 0x140 also predicts 1.
- Illegal and reset:
  - funct3 = 010 → br_illegal = 1, res_taken = 0, counter unchanged.
  - Assert rst in the cycle after a taken resolve → pending update dropped, counter reads 01.
